// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared types and constants for the CPU control unit and its register file.
//   instr_class_t : instruction class encoding held in instr[15:12]
//   ctrl_state_t  : sequencer states
//   FLAG_*        : bit positions inside the {Z,C,S,O} flag nibble
//   ALU_*         : ALU mode codes the surrounding system relies on
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        CLS_ALU  = 4'h0,
        CLS_CMP  = 4'h1,
        CLS_LDI  = 4'h2,
        CLS_STA  = 4'h3,
        CLS_ALUI = 4'h4,
        CLS_JMP  = 4'h5,
        CLS_JZ   = 4'h6,
        CLS_JC   = 4'h7,
        CLS_HALT = 4'hF
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } ctrl_state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_S = 1;
    localparam int FLAG_O = 0;

    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_PASS2 = 4'h3;
    localparam logic [3:0] ALU_INC   = 4'h8;

    // Classes whose execution drives the ALU with a real mode and operands.
    function automatic logic uses_alu(input logic [3:0] cls);
        return (cls == CLS_ALU) || (cls == CLS_CMP) || (cls == CLS_ALUI);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile
// NREG x 8-bit register file, one asynchronous read port and one
// synchronous write port. All entries clear on reset.
//   clk, rst         : clock, async active-high reset
//   rd_idx / rd_data : combinational read (indices >= NREG read as 0)
//   wr_en/idx/data   : write on the rising clock edge
module cpu_regfile
    import cpu_ctrl_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rd_idx,
    output logic [7:0] rd_data,
    input  logic       wr_en,
    input  logic [3:0] wr_idx,
    input  logic [7:0] wr_data
);

    localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;

    logic [7:0] regs [NREG];

    // Out-of-range indices (only possible when NREG < 16) read as zero.
    always_comb begin
        rd_data = '0;
        if (int'(rd_idx) < NREG) begin
            rd_data = regs[rd_idx[IDX_W-1:0]];
        end
    end

    // Out-of-range writes are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (int'(wr_idx) < NREG)) begin
            regs[wr_idx[IDX_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Sequencer in front of the 8-bit ALU: fetches 16-bit instructions over a
// req/ack handshake, decodes them into ALU mode/operands and owns the
// accumulator, flag register and register file.
//   clk, rst                 : clock, async active-high reset
//   start                    : pulse that leaves IDLE and begins fetching at PC 0
//   imem_req/addr/ack/data   : instruction fetch handshake
//   alu_mode/op1/op2/en      : ALU drive, non-zero only during EXEC
//   alu_cflags               : current flag register {Z,C,S,O}
//   alu_out, alu_flags       : ALU result and flags captured at the EXEC edge
//   acc                      : accumulator
//   halted                   : in HALT state
//   illegal                  : sticky undefined-class indicator
// Build option: define CPU_CTRL_ILLEGAL_TRAP_EN to trap classes 8-E into
// HALT with illegal=1; otherwise they behave as NOPs and illegal is 0.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [3:0]      alu_mode,
    output logic [7:0]      alu_op1,
    output logic [7:0]      alu_op2,
    output logic            alu_en,
    output logic [3:0]      alu_cflags,
    input  logic [7:0]      alu_out,
    input  logic [3:0]      alu_flags,
    output logic [7:0]      acc,
    output logic            halted,
    output logic            illegal
);

    ctrl_state_t     state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      flags;

    logic [3:0]      cls;
    logic [7:0]      field;
    logic [7:0]      reg_rd_data;
    logic            reg_wr_en;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    assign cls        = ir[15:12];
    assign field      = ir[7:0];
    assign imem_addr  = pc;
    assign alu_cflags = flags;
    assign pc_inc     = pc + PC_W'(1);
    assign target     = PC_W'(field);

    // STA commits on the EXEC edge, so a following instruction already
    // sees the new register value through the asynchronous read port.
    assign reg_wr_en = (state == ST_EXEC) && (cls == CLS_STA);

    cpu_regfile #(
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (ir[3:0]),
        .rd_data (reg_rd_data),
        .wr_en   (reg_wr_en),
        .wr_idx  (ir[3:0]),
        .wr_data (acc)
    );

    // ALU drive is decoded straight from the instruction register; anything
    // that is not an ALU-using class in EXEC presents an all-zero request.
    always_comb begin
        alu_en   = 1'b0;
        alu_mode = '0;
        alu_op1  = '0;
        alu_op2  = '0;
        if (state == ST_EXEC) begin
            alu_en = 1'b1;
            if (uses_alu(cls)) begin
                alu_mode = ir[11:8];
                alu_op1  = (cls == CLS_ALUI) ? field : reg_rd_data;
                alu_op2  = acc;
            end
        end
    end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    // Sequencer. imem_req and halted are registered alongside the state so
    // reset drops the fetch request immediately and a pending ack is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= '0;
            ir       <= '0;
            acc      <= '0;
            flags    <= '0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        pc       <= '0;
                        imem_req <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                    pc       <= pc_inc;
                    case (cls)
                        CLS_ALU, CLS_ALUI: begin
                            acc   <= alu_out;
                            flags <= alu_flags;
                        end
                        CLS_CMP: flags <= alu_flags;
                        CLS_LDI: acc <= field;
                        CLS_STA: ;
                        CLS_JMP: pc <= target;
                        CLS_JZ:  if (flags[FLAG_Z]) pc <= target;
                        CLS_JC:  if (flags[FLAG_C]) pc <= target;
                        CLS_HALT: begin
                            state    <= ST_HALT;
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                        end
                        default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                            // Trap leaves PC on the offending instruction.
                            illegal_q <= 1'b1;
                            state     <= ST_HALT;
                            imem_req  <= 1'b0;
                            halted    <= 1'b1;
                            pc        <= pc;
`endif
                        end
                    endcase
                end
                ST_HALT: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit
// Directed and randomized bench for cpu_control_unit. The bench plays both
// the instruction memory (configurable ack latency) and the external ALU,
// and runs an instruction-level model of the programmer-visible state.
// Honours CPU_CTRL_ILLEGAL_TRAP_EN the same way the design does.
module tb_cpu_control_unit;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [3:0]  alu_mode;
    logic [7:0]  alu_op1;
    logic [7:0]  alu_op2;
    logic        alu_en;
    logic [3:0]  alu_cflags;
    logic [7:0]  alu_out;
    logic [3:0]  alu_flags;
    logic [7:0]  acc;
    logic        halted;
    logic        illegal;

    int checks;
    int errors;

    always #5 clk = ~clk;

    cpu_control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .alu_mode   (alu_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_en     (alu_en),
        .alu_cflags (alu_cflags),
        .alu_out    (alu_out),
        .alu_flags  (alu_flags),
        .acc        (acc),
        .halted     (halted),
        .illegal    (illegal)
    );

    // Instruction memory: ack comes ack_lat cycles after req rises.
    logic [15:0] imem [256];
    int          ack_lat = 0;
    logic        ack_force = 1'b0;
    int          wait_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    assign imem_ack  = (imem_req && (wait_cnt >= ack_lat)) || ack_force;
    assign imem_data = imem[imem_addr];

    // External ALU: returns {Z,C,S,O, result}.
    function automatic logic [11:0] aluRef(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] r;
        logic       c;
        logic       o;
        w = '0; c = 1'b0; o = 1'b0;
        case (m)
            ALU_ADD: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0]; c = w[8];
                o = (a[7] == b[7]) && (r[7] != a[7]);
            end
            ALU_SUB: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0]; c = w[8];
                o = (a[7] != b[7]) && (r[7] != a[7]);
            end
            ALU_PASS2: r = b;
            ALU_INC: begin
                w = {1'b0, a} + 9'd1;
                r = w[7:0]; c = w[8];
            end
            default: r = a ^ b;
        endcase
        return {(r == 8'h00), c, r[7], o, r};
    endfunction

    always_comb {alu_flags, alu_out} = aluRef(alu_mode, alu_op1, alu_op2);

    // Instruction-level model state.
    logic [7:0] m_pc;
    logic [7:0] m_acc;
    logic [3:0] m_flags;
    logic [7:0] m_regs [16];
    logic       m_halted;
    logic       m_illegal;

    task automatic modelReset();
        m_pc = 8'h00; m_acc = 8'h00; m_flags = 4'h0;
        m_halted = 1'b0; m_illegal = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h2000;
    endtask

    // Reset, then pulse start; returns at the first FETCH negedge.
    task automatic applyStimulus(input int lat);
        ack_lat = lat;
        rst = 1'b1; start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs one instruction from a FETCH negedge to the negedge after EXEC,
    // checking the fetch, the ALU drive and the resulting visible state.
    task automatic stepInstr();
        int          fc;
        logic [15:0] ins;
        logic [3:0]  cls;
        logic [3:0]  e_mode;
        logic [7:0]  fld;
        logic [7:0]  e_op1;
        logic [7:0]  e_op2;
        logic [7:0]  next_pc;
        logic [11:0] r;
        fc = 0;
        while (alu_en !== 1'b1 && fc < 40) begin
            checkOutput("fetch_req", 16'(imem_req), 16'h1);
            checkOutput("fetch_addr", 16'(imem_addr), 16'(m_pc));
            fc++;
            @(negedge clk);
        end
        if (alu_en !== 1'b1) begin
            checkOutput("exec_timeout", 16'(alu_en), 16'h1);
            return;
        end
        checkOutput("fetch_cycles", 16'(fc), 16'(ack_lat + 1));

        ins = imem[m_pc];
        cls = ins[15:12];
        fld = ins[7:0];
        e_mode = 4'h0; e_op1 = 8'h00; e_op2 = 8'h00;
        if (cls == 4'h0 || cls == 4'h1) begin
            e_mode = ins[11:8]; e_op1 = m_regs[fld[3:0]]; e_op2 = m_acc;
        end else if (cls == 4'h4) begin
            e_mode = ins[11:8]; e_op1 = fld; e_op2 = m_acc;
        end
        checkOutput("alu_mode", 16'(alu_mode), 16'(e_mode));
        checkOutput("alu_op1", 16'(alu_op1), 16'(e_op1));
        checkOutput("alu_op2", 16'(alu_op2), 16'(e_op2));

        r = aluRef(e_mode, e_op1, e_op2);
        next_pc = m_pc + 8'd1;
        case (cls)
            4'h0, 4'h4: begin m_acc = r[7:0]; m_flags = r[11:8]; end
            4'h1: m_flags = r[11:8];
            4'h2: m_acc = fld;
            4'h3: m_regs[fld[3:0]] = m_acc;
            4'h5: next_pc = fld;
            4'h6: if (m_flags[3]) next_pc = fld;
            4'h7: if (m_flags[2]) next_pc = fld;
            4'hF: m_halted = 1'b1;
            default: begin
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
                m_illegal = 1'b1;
                m_halted  = 1'b1;
                next_pc   = m_pc;
`endif
            end
        endcase
        m_pc = next_pc;

        @(negedge clk);
        checkOutput("acc", 16'(acc), 16'(m_acc));
        checkOutput("cflags", 16'(alu_cflags), 16'(m_flags));
        checkOutput("halted", 16'(halted), 16'(m_halted));
        checkOutput("illegal", 16'(illegal), 16'(m_illegal));
        checkOutput("alu_en_off", 16'(alu_en), 16'h0);
        if (m_halted) begin
            checkOutput("halt_no_req", 16'(imem_req), 16'h0);
        end else begin
            checkOutput("next_req", 16'(imem_req), 16'h1);
            checkOutput("next_addr", 16'(imem_addr), 16'(m_pc));
        end
    endtask

    function automatic logic [15:0] randInstr();
        logic [3:0] c;
        logic [3:0] m;
        c = 4'($urandom_range(0, 8));
        if ($urandom_range(0, 31) == 0) c = 4'hF;
        case ($urandom_range(0, 4))
            0: m = ALU_ADD;
            1: m = ALU_SUB;
            2: m = ALU_PASS2;
            3: m = ALU_INC;
            default: m = 4'($urandom_range(0, 15));
        endcase
        return {c, m, 8'($urandom_range(0, 255))};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        clearMem();
        modelReset();

        // Reset state, then an ack while IDLE must be ignored.
        @(negedge clk);
        checkOutput("rst_req", 16'(imem_req), 16'h0);
        checkOutput("rst_alu_en", 16'(alu_en), 16'h0);
        checkOutput("rst_halted", 16'(halted), 16'h0);
        checkOutput("rst_illegal", 16'(illegal), 16'h0);
        checkOutput("rst_acc", 16'(acc), 16'h0);
        checkOutput("rst_cflags", 16'(alu_cflags), 16'h0);
        checkOutput("rst_mode", 16'({alu_mode, alu_op1, alu_op2} != 20'h0), 16'h0);
        rst = 1'b0;
        ack_force = 1'b1;
        repeat (2) @(negedge clk);
        ack_force = 1'b0;
        checkOutput("idle_ack_req", 16'(imem_req), 16'h0);
        checkOutput("idle_ack_en", 16'(alu_en), 16'h0);

        // LDI 5; ALUI ADD 3 with a two-cycle memory.
        clearMem();
        imem[0] = 16'h2005; imem[1] = 16'h4003;
        applyStimulus(2);
        repeat (2) stepInstr();
        checkOutput("p1_acc", 16'(acc), 16'h08);
        checkOutput("p1_z", 16'(alu_cflags[FLAG_Z]), 16'h0);

        // LDI FF; STA R2; LDI 1; ALU ADD R2 -> wraps to zero.
        clearMem();
        imem[0] = 16'h20FF; imem[1] = 16'h3002; imem[2] = 16'h2001; imem[3] = 16'h0002;
        applyStimulus(0);
        repeat (3) stepInstr();
        stepInstr();
        checkOutput("p2_acc", 16'(acc), 16'h00);
        checkOutput("p2_z", 16'(alu_cflags[FLAG_Z]), 16'h1);

        // JZ taken, JZ not taken, JMP FF then wrap to 0.
        clearMem();
        imem[8'h00] = 16'h2000; imem[8'h01] = 16'h1100; imem[8'h02] = 16'h6040;
        imem[8'h40] = 16'h2001; imem[8'h41] = 16'h3000; imem[8'h42] = 16'h2000;
        imem[8'h43] = 16'h1100; imem[8'h44] = 16'h6040; imem[8'h45] = 16'h50FF;
        imem[8'hFF] = 16'h2055;
        applyStimulus(1);
        repeat (3) stepInstr();
        checkOutput("jz_taken", 16'(imem_addr), 16'h0040);
        repeat (5) stepInstr();
        checkOutput("jz_not_taken", 16'(imem_addr), 16'h0045);
        repeat (2) stepInstr();
        checkOutput("pc_wrap", 16'(imem_addr), 16'h0000);
        stepInstr();

        // HALT ignores later start pulses.
        clearMem();
        imem[0] = 16'h2033; imem[1] = 16'hF000;
        applyStimulus(0);
        repeat (2) stepInstr();
        checkOutput("halt_flag", 16'(halted), 16'h1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            checkOutput("halt_start_req", 16'(imem_req), 16'h0);
        end

        // Reset in the middle of a slow fetch.
        clearMem();
        imem[0] = 16'h2077; imem[1] = 16'h2011;
        applyStimulus(4);
        stepInstr();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 checkOutput("rst_mid_req", 16'(imem_req), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkOutput("rst_mid_acc", 16'(acc), 16'h0);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_mid_idle", 16'(imem_req), 16'h0);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stepInstr();

        // Undefined class 9.
        clearMem();
        imem[0] = 16'h9000; imem[1] = 16'h2012;
        applyStimulus(0);
        stepInstr();
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
        checkOutput("trap_illegal", 16'(illegal), 16'h1);
        checkOutput("trap_halted", 16'(halted), 16'h1);
`else
        checkOutput("nop_addr", 16'(imem_addr), 16'h0001);
        stepInstr();
        checkOutput("nop_acc", 16'(acc), 16'h12);
        checkOutput("nop_illegal", 16'(illegal), 16'h0);
`endif

        // Random programs over the whole address space.
        for (int run = 0; run < 6; run++) begin
            for (int i = 0; i < 256; i++) imem[i] = randInstr();
            applyStimulus(int'($urandom_range(0, 3)));
            for (int k = 0; k < 30 && !m_halted; k++) stepInstr();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
